// File: rtl/bash_line_writer.sv
// bash_line_writer: buffers command output bytes in a first-word-fall-through
// FIFO and frames them into console lines (0x00 ends a line), then signals
// command completion with in_solved and waits for the console's out_solved.
module bash_line_writer #(
  parameter int FIFO_AW     = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             cmd_done,
  output logic             fifo_full,
  output logic [FIFO_AW:0] fifo_count,
  output logic             overflow,
  input  logic             vm_line_busy,
  output logic [7:0]       lineIn,
  output logic             in_newASCII_ready,
  input  logic             lineIn_nextASCII,
  output logic             in_solved,
  input  logic             out_solved,
  output logic             busy,
  output logic             timeout_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_TERM  = 2'd1;
  localparam logic [1:0] S_SOLVE = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic [7:0] CH_NUL = 8'h00;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;

  localparam logic [FIFO_AW:0]   CNT_ZERO  = {(FIFO_AW+1){1'b0}};
  localparam logic [FIFO_AW:0]   CNT_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]      TMR_ZERO  = {TW{1'b0}};
  localparam logic [TW-1:0]      TMR_ONE   = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]      TMR_LAST  = TW'(TIMEOUT_CYC - 1);

  // Storage and registered state
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [1:0]         state_q, state_d;
  logic               done_pend_q, done_pend_d;
  logic               line_open_q, line_open_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               timeout_err_q, timeout_err_d;

  // Decoded FIFO/handshake conditions
  logic [7:0] head_s;
  logic       empty_s;
  logic       full_s;
  logic       skip_s;
  logic       pop_s;
  logic       push_s;

  assign head_s  = mem_q[rd_ptr_q];
  assign empty_s = (count_q == CNT_ZERO);
  assign full_s  = (count_q == CNT_FULL);
  // CR and NUL at the head are discarded without being shown to the console
  assign skip_s  = (head_s == CH_CR) || (head_s == CH_NUL);

  // FIFO pointer/count bookkeeping, overflow detection and pop/push decisions
  always_comb begin
    pop_s      = (state_q == S_RUN) && !empty_s && (skip_s || lineIn_nextASCII);
    // a full FIFO can still take a byte when the head leaves in the same cycle
    push_s     = wr_en && (!full_s || pop_s);
    overflow_d = overflow_q || (wr_en && full_s && !pop_s);

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Line framing, completion bookkeeping and the solve/ack state machine
  always_comb begin
    state_d       = state_q;
    line_open_d   = line_open_q;
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;

    if (cmd_done) begin
      done_pend_d = 1'b1;
    end else if (state_q == S_SOLVE) begin
      done_pend_d = 1'b0;
    end else begin
      done_pend_d = done_pend_q;
    end

    case (state_q)
      S_RUN: begin
        if (pop_s) begin
          if (head_s == CH_LF) begin
            line_open_d = 1'b0;
          end else if (!skip_s) begin
            line_open_d = 1'b1;
          end else begin
            line_open_d = line_open_q;
          end
        end else begin
          line_open_d = line_open_q;
        end
        if (done_pend_q && empty_s && line_open_q && !pop_s) begin
          state_d = S_TERM;
        end else if (done_pend_q && empty_s && !line_open_q) begin
          state_d = S_SOLVE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_TERM: begin
        if (lineIn_nextASCII) begin
          state_d     = S_SOLVE;
          line_open_d = 1'b0;
        end else begin
          state_d = S_TERM;
        end
      end
      S_SOLVE: begin
        timer_d = TMR_ZERO;
        state_d = S_ACK;
      end
      S_ACK: begin
        timer_d = timer_q + TMR_ONE;
        if (out_solved) begin
          state_d = S_RUN;
        end else if (timer_q == TMR_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_RUN;
        end else begin
          state_d = S_ACK;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // FIFO data storage (contents need no reset; validity comes from count)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= {FIFO_AW{1'b0}};
      rd_ptr_q      <= {FIFO_AW{1'b0}};
      count_q       <= CNT_ZERO;
      overflow_q    <= 1'b0;
      state_q       <= S_RUN;
      done_pend_q   <= 1'b0;
      line_open_q   <= 1'b0;
      timer_q       <= TMR_ZERO;
      timeout_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      state_q       <= state_d;
      done_pend_q   <= done_pend_d;
      line_open_q   <= line_open_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Console-facing outputs decoded from registered state and the FIFO head;
  // lineIn is forced to 0x00 while the FIFO is empty so stale memory never shows
  always_comb begin
    if ((state_q == S_TERM) || empty_s || (head_s == CH_LF)) begin
      lineIn = CH_NUL;
    end else begin
      lineIn = head_s;
    end
    in_newASCII_ready = ((state_q == S_RUN) && !empty_s && !vm_line_busy && !skip_s)
                        || (state_q == S_TERM);
    in_solved         = (state_q == S_SOLVE);
    busy              = !empty_s || done_pend_q || (state_q != S_RUN);
  end

  assign fifo_full   = full_s;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bash_line_writer.sv
// Self-checking bench for bash_line_writer: a console model consumes bytes
// and acks solves, while a stream model predicts every byte and solve.
module tb_bash_line_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       cmd_done;
  logic       fifo_full;
  logic [8:0] fifo_count;
  logic       overflow;
  logic       vm_line_busy;
  logic [7:0] lineIn;
  logic       in_newASCII_ready;
  logic       lineIn_nextASCII;
  logic       in_solved;
  logic       out_solved;
  logic       busy;
  logic       timeout_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // behavioural model state
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         exp_solves  = 0;
  int         solves_seen = 0;
  int         ready_seen  = 0;
  int         m_fill      = 0;
  bit         open_m      = 1'b0;
  bit         con_en      = 1'b0;
  bit         ack_en      = 1'b1;
  bit         ack_pend    = 1'b0;
  int         cmd_cyc     = 0;
  int         solve_cyc   = 0;

  bash_line_writer #(.FIFO_AW(8), .TIMEOUT_CYC(1024)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr_en             (wr_en),
    .wr_data           (wr_data),
    .cmd_done          (cmd_done),
    .fifo_full         (fifo_full),
    .fifo_count        (fifo_count),
    .overflow          (overflow),
    .vm_line_busy      (vm_line_busy),
    .lineIn            (lineIn),
    .in_newASCII_ready (in_newASCII_ready),
    .lineIn_nextASCII  (lineIn_nextASCII),
    .in_solved         (in_solved),
    .out_solved        (out_solved),
    .busy              (busy),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of one pushed byte: CR/NUL vanish, LF becomes 0x00, rest pass through
  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    if (m_fill < 256) begin
      m_fill = m_fill + 1;
      if (b == 8'h0A) begin
        exp_q.push_back(8'h00);
        open_m = 1'b0;
      end else if (b != 8'h0D && b != 8'h00) begin
        exp_q.push_back(b);
        open_m = 1'b1;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Command end: an open line is owed a terminator, then one solve
  task automatic do_cmd_done();
    @(negedge clk);
    cmd_done = 1'b1;
    cmd_cyc  = cyc;
    if (open_m) exp_q.push_back(8'h00);
    open_m     = 1'b0;
    exp_solves = exp_solves + 1;
    @(negedge clk);
    cmd_done = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while ((busy || exp_q.size() != 0 || exp_solves != 0) && n < limit);
    chk({name, "_timeout"}, 32'(n >= limit), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_count"}, 32'(fifo_count), 32'd0);
  endtask

  // Console model and per-cycle compare against the stream model
  always @(negedge clk) begin
    if (rst_n) begin
      if (lineIn_nextASCII) begin
        lineIn_nextASCII = 1'b0;
      end else if (in_newASCII_ready) begin
        ready_seen = ready_seen + 1;
        if (con_en) begin
          if (exp_q.size() == 0) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL unexpected_byte: got %02h expected no byte", lineIn);
          end else begin
            chk("stream_byte", 32'(lineIn), 32'(exp_q.pop_front()));
          end
          got_q.push_back(lineIn);
          lineIn_nextASCII = 1'b1;
        end
      end
      if (out_solved) out_solved = 1'b0;
      if (ack_pend) begin
        out_solved = 1'b1;
        ack_pend   = 1'b0;
      end
      if (in_solved) begin
        solve_cyc   = cyc;
        solves_seen = solves_seen + 1;
        tests       = tests + 1;
        if (exp_q.size() != 0 || exp_solves == 0) begin
          fails = fails + 1;
          $display("FAIL unexpected_solve: got solve with %0d bytes pending, %0d solves owed",
                   exp_q.size(), exp_solves);
        end else begin
          exp_solves = exp_solves - 1;
        end
        if (ack_en) ack_pend = 1'b1;
      end
    end else begin
      lineIn_nextASCII = 1'b0;
      out_solved       = 1'b0;
      ack_pend         = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    cmd_done     = 1'b0;
    vm_line_busy = 1'b0;
    lineIn_nextASCII = 1'b0;
    out_solved   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_lineIn", 32'(lineIn), 32'd0);
    chk("rst_ready", 32'(in_newASCII_ready), 32'd0);
    chk("rst_solved", 32'(in_solved), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: "ls\n" -> 6C 73 00, one solve; first byte ready right after push edge
    got_q.delete(); solves_seen = 0;
    push_byte(8'h6C);
    chk("t1_ready_latency", 32'(in_newASCII_ready), 32'd1);
    chk("t1_first_lineIn", 32'(lineIn), 32'h6C);
    chk("t1_count1", 32'(fifo_count), 32'd1);
    con_en = 1'b1;
    push_byte(8'h73);
    push_byte(8'h0A);
    do_cmd_done();
    wait_idle("t1", 200);
    chk("t1_len", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("t1_b0", 32'(got_q[0]), 32'h6C);
      chk("t1_b1", 32'(got_q[1]), 32'h73);
      chk("t1_b2", 32'(got_q[2]), 32'h00);
    end
    chk("t1_solves", 32'(solves_seen), 32'd1);

    // T2: "ab" without LF -> 61 62 then synthesized 00, one solve
    got_q.delete(); solves_seen = 0;
    push_byte(8'h61);
    push_byte(8'h62);
    do_cmd_done();
    wait_idle("t2", 200);
    chk("t2_len", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("t2_b0", 32'(got_q[0]), 32'h61);
      chk("t2_b1", 32'(got_q[1]), 32'h62);
      chk("t2_term", 32'(got_q[2]), 32'h00);
    end
    chk("t2_solves", 32'(solves_seen), 32'd1);

    // T3: cmd_done on empty FIFO with no open line
    got_q.delete(); solves_seen = 0; ready_seen = 0;
    do_cmd_done();
    wait_idle("t3", 50);
    chk("t3_solves", 32'(solves_seen), 32'd1);
    chk("t3_latency_le2", 32'((solve_cyc - cmd_cyc) <= 2), 32'd1);
    chk("t3_no_ready", 32'(ready_seen), 32'd0);

    // T4: 257 pushes with no console: full, 256 held, overflow, order kept
    got_q.delete(); solves_seen = 0; m_fill = 0; con_en = 1'b0;
    for (int i = 0; i < 257; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'h20 + 8'(i % 90);
      if (m_fill < 256) begin
        m_fill = m_fill + 1;
        exp_q.push_back(wr_data);
        open_m = 1'b1;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("t4_full", 32'(fifo_full), 32'd1);
    chk("t4_count", 32'(fifo_count), 32'd256);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_model_fill", 32'(exp_q.size()), 32'd256);
    con_en = 1'b1;
    do_cmd_done();
    wait_idle("t4", 2000);
    chk("t4_len", 32'(got_q.size()), 32'd257);
    if (got_q.size() == 257) begin
      chk("t4_first", 32'(got_q[0]), 32'h20);
      chk("t4_last", 32'(got_q[255]), 32'h6B);
      chk("t4_term", 32'(got_q[256]), 32'h00);
    end
    chk("t4_solves", 32'(solves_seen), 32'd1);
    chk("t4_overflow_sticky", 32'(overflow), 32'd1);

    // T5: 'x',CR,LF behind vm_line_busy -> ready low, then 78 00
    got_q.delete(); solves_seen = 0; m_fill = 0;
    @(negedge clk);
    vm_line_busy = 1'b1;
    push_byte(8'h78);
    push_byte(8'h0D);
    push_byte(8'h0A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_ready_low", 32'(in_newASCII_ready), 32'd0);
    end
    vm_line_busy = 1'b0;
    do_cmd_done();
    wait_idle("t5", 200);
    chk("t5_len", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk("t5_b0", 32'(got_q[0]), 32'h78);
      chk("t5_b1", 32'(got_q[1]), 32'h00);
    end

    // T6: withhold out_solved -> timeout_err after 1024 cycles in ack wait
    solves_seen = 0; ack_en = 1'b0;
    do_cmd_done();
    n = 0;
    while (!in_solved && n < 10) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("t6_solve_seen", 32'(in_solved), 32'd1);
    repeat (1024) @(negedge clk);
    chk("t6_no_err_yet", 32'(timeout_err), 32'd0);
    @(negedge clk);
    chk("t6_timeout_err", 32'(timeout_err), 32'd1);
    chk("t6_busy_after", 32'(busy), 32'd0);
    ack_en = 1'b1;

    // Reset mid-line: everything clears at once and no terminator is owed
    con_en = 1'b0; m_fill = 0;
    push_byte(8'h71);
    push_byte(8'h72);
    chk("rm_ready_before", 32'(in_newASCII_ready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_ready", 32'(in_newASCII_ready), 32'd0);
    chk("rm_solved", 32'(in_solved), 32'd0);
    chk("rm_count", 32'(fifo_count), 32'd0);
    chk("rm_overflow", 32'(overflow), 32'd0);
    chk("rm_timeout", 32'(timeout_err), 32'd0);
    exp_q.delete(); exp_solves = 0; open_m = 1'b0; m_fill = 0;
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete(); solves_seen = 0; con_en = 1'b1;
    do_cmd_done();
    wait_idle("rm", 50);
    chk("rm_no_term", 32'(got_q.size()), 32'd0);
    chk("rm_solves", 32'(solves_seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
